// File: rtl/alu_writeback_stage_pkg.sv
// Shared opcode/compare encodings, FSM state type and result-entry layout for the ALU write-back
// stage. The optional error trap is enabled with the ALU_WB_ERROR_TRAP_EN macro.
package alu_writeback_stage_pkg;

    localparam int unsigned ALU_DATA_W = 16;
    localparam int unsigned OP_W       = 4;
    localparam int unsigned CMP_W      = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_AND = 4'd1,
        OP_OR  = 4'd2,
        OP_SHL = 4'd3,
        OP_SHR = 4'd4,
        OP_SUB = 4'd5
    } alu_op_e;

    typedef enum logic [CMP_W-1:0] {
        CMP_EQ = 2'b00,
        CMP_GT = 2'b01,
        CMP_LT = 2'b11
    } alu_cmp_e;

    typedef enum logic {StRun, StTrap} wb_state_e;

    // Entry layout, LSB first: error, zero, cout, cmp, r, rd, op.
    localparam int unsigned ERR_OFF  = 0;
    localparam int unsigned ZERO_OFF = 1;
    localparam int unsigned COUT_OFF = 2;
    localparam int unsigned CMP_OFF  = 3;
    localparam int unsigned R_OFF    = CMP_OFF + CMP_W;

    function automatic int unsigned rd_off(int unsigned data_w);
        return R_OFF + data_w;
    endfunction

    function automatic int unsigned op_off(int unsigned data_w, int unsigned rd_w);
        return R_OFF + data_w + rd_w;
    endfunction

    function automatic int unsigned entry_w(int unsigned data_w, int unsigned rd_w);
        return op_off(data_w, rd_w) + OP_W;
    endfunction

endpackage

// File: rtl/alu_writeback_stage_if.sv
// Handshake bundle between the ALU, the write-back stage and the register-file write port.
// The master side is the ALU/register-file environment, the slave side is the stage itself.
interface alu_writeback_stage_if
    import alu_writeback_stage_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W,
    parameter int unsigned RD_W   = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [RD_W-1:0]   in_rd;
    logic [DATA_W-1:0] in_r;
    logic              in_cout;
    logic              in_zero;
    logic              in_error;
    logic [CMP_W-1:0]  in_cmp;
    logic              wb_valid;
    logic              wb_ready;
    logic [RD_W-1:0]   wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              flag_c;
    logic              flag_z;
    logic [CMP_W-1:0]  flag_cmp;
    logic              err_sticky;
    logic              trap;
    logic              trap_clear;

    modport master (
        output in_valid, in_op, in_rd, in_r, in_cout, in_zero, in_error, in_cmp, wb_ready,
               trap_clear,
        input  in_ready, wb_valid, wb_rd, wb_data, flag_c, flag_z, flag_cmp, err_sticky, trap
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_r, in_cout, in_zero, in_error, in_cmp, wb_ready,
               trap_clear,
        output in_ready, wb_valid, wb_rd, wb_data, flag_c, flag_z, flag_cmp, err_sticky, trap
    );

endinterface

// File: rtl/alu_wb_fifo.sv
// Generic DEPTH-entry circular buffer with occupancy count, push/pop and a head view.
// DEPTH must be a power of two (>= 2) so the pointers wrap by natural overflow.
module alu_wb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/alu_writeback_stage.sv
// Buffers ALU results and presents them to the register-file write port; keeps the flag register.
// Define ALU_WB_ERROR_TRAP_EN to halt on an error entry until trap_clear instead of dropping it.
module alu_writeback_stage
    import alu_writeback_stage_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W,
    parameter int unsigned RD_W   = 4,
    parameter int unsigned DEPTH  = 2
) (
    input logic                  clk,
    input logic                  reset,
    alu_writeback_stage_if.slave bus
);
    localparam int unsigned RdOff  = rd_off(DATA_W);
    localparam int unsigned OpOff  = op_off(DATA_W, RD_W);
    localparam int unsigned EntryW = entry_w(DATA_W, RD_W);
    localparam int unsigned CntW   = $clog2(DEPTH) + 1;

    logic [EntryW-1:0] entry_in;
    logic [EntryW-1:0] head;
    logic [CntW-1:0]   count;
    logic              full;
    logic              empty;
    logic              run;
    logic              push;
    logic              pop;
    logic              retire;
    logic              head_err;
    logic              err_set;
    logic              trap;
    logic [OP_W-1:0]   head_op;
    wb_state_e         state_q;

    logic              flag_c_q;
    logic              flag_z_q;
    logic [CMP_W-1:0]  flag_cmp_q;
    logic              err_sticky_q;

    assign entry_in = {bus.in_op, bus.in_rd, bus.in_r, bus.in_cmp, bus.in_cout, bus.in_zero,
                       bus.in_error};

    alu_wb_fifo #(
        .WIDTH (EntryW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (entry_in),
        .head  (head),
        .count (count)
    );

    assign full     = (count == CntW'(DEPTH));
    assign empty    = (count == '0);
    assign run      = (state_q == StRun);
    assign head_op  = head[OpOff +: OP_W];
    assign head_err = !empty && head[ERR_OFF];
    assign err_set  = head_err && run;

    // in_ready depends only on registered state (and reset), never on wb_ready.
    assign bus.in_ready = !reset && !full && run;
    assign bus.wb_valid = !empty && !head[ERR_OFF] && run;
    assign bus.wb_rd    = empty ? '0 : head[RdOff +: RD_W];
    assign bus.wb_data  = empty ? '0 : head[R_OFF +: DATA_W];

    assign push   = bus.in_valid && bus.in_ready;
    assign retire = bus.wb_valid && bus.wb_ready;

`ifdef ALU_WB_ERROR_TRAP_EN
    wb_state_e state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:  if (head_err) state_d = StTrap;
            StTrap: if (bus.trap_clear) state_d = StRun;
        endcase
    end

    // The error entry stays at the head throughout TRAP and leaves only on trap_clear.
    always_comb begin
        pop  = retire;
        trap = 1'b0;
        if (state_q == StTrap) begin
            trap = 1'b1;
            pop  = bus.trap_clear;
        end
    end
`else
    logic unused_trap_clear;

    assign state_q           = StRun;
    assign unused_trap_clear = bus.trap_clear;

    // Error entries are discarded the cycle they reach the head.
    always_comb begin
        pop  = retire || head_err;
        trap = 1'b0;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_c_q     <= 1'b0;
            flag_z_q     <= 1'b0;
            flag_cmp_q   <= CMP_EQ;
            err_sticky_q <= 1'b0;
        end else begin
            if (err_set) begin
                err_sticky_q <= 1'b1;
            end
            if (retire) begin
                flag_z_q <= head[ZERO_OFF];
                if (head_op == OP_ADD || head_op == OP_SUB) begin
                    flag_c_q <= head[COUT_OFF];
                end
                if (head_op == OP_SUB) begin
                    flag_cmp_q <= head[CMP_OFF +: CMP_W];
                end
            end
        end
    end

    assign bus.flag_c     = flag_c_q;
    assign bus.flag_z     = flag_z_q;
    assign bus.flag_cmp   = flag_cmp_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.trap       = trap;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Self-checking bench for alu_writeback_stage: directed scenarios plus random traffic checked
// against a queue-based model of the buffer and flag register.
module tb_alu_writeback_stage;

    localparam int DATA_W = 16;
    localparam int RD_W   = 4;
    localparam int DEPTH  = 2;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [15:0] r;
        logic        cout;
        logic        zero;
        logic        err;
        logic [1:0]  cmp;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_writeback_stage_if #(.DATA_W(DATA_W), .RD_W(RD_W)) bus ();

    alu_writeback_stage #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ent_t       q[$];
    logic       m_c;
    logic       m_z;
    logic [1:0] m_cmp;
    logic       m_sticky;
    logic       m_trap;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_c = 1'b0;
        m_z = 1'b0;
        m_cmp = 2'b00;
        m_sticky = 1'b0;
        m_trap = 1'b0;
    endtask

    function automatic ent_t mk(input int op, input int rd, input int r, input bit cout,
                                input bit zero, input bit err, input int cmp);
        ent_t e;
        e.op = 4'(op);
        e.rd = 4'(rd);
        e.r = 16'(r);
        e.cout = cout;
        e.zero = zero;
        e.err = err;
        e.cmp = 2'(cmp);
        return e;
    endfunction

    function automatic ent_t rand_ent();
        return mk($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 65535),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3));
    endfunction

    task automatic check_static(input string pfx);
        chk({pfx, "_flag_c"}, bus.flag_c, m_c);
        chk({pfx, "_flag_z"}, bus.flag_z, m_z);
        chk({pfx, "_flag_cmp"}, bus.flag_cmp, m_cmp);
        chk({pfx, "_err_sticky"}, bus.err_sticky, m_sticky);
        chk({pfx, "_trap"}, bus.trap, m_trap);
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model past the rising edge.
    task automatic step(input bit v, input ent_t e, input bit rdy, input bit clr, output bit acc);
        bit exp_ready;
        bit exp_valid;
        bit ret;
        bit pop;
        @(negedge clk);
        bus.in_valid = v;
        bus.in_op = e.op;
        bus.in_rd = e.rd;
        bus.in_r = e.r;
        bus.in_cout = e.cout;
        bus.in_zero = e.zero;
        bus.in_error = e.err;
        bus.in_cmp = e.cmp;
        bus.wb_ready = rdy;
        bus.trap_clear = clr;
        #1;
        exp_ready = (q.size() < DEPTH) && !m_trap;
        exp_valid = (q.size() > 0) && !q[0].err && !m_trap;
        chk("in_ready", bus.in_ready, exp_ready);
        chk("wb_valid", bus.wb_valid, exp_valid);
        if (q.size() == 0) begin
            chk("wb_data_empty", bus.wb_data, 0);
            chk("wb_rd_empty", bus.wb_rd, 0);
        end else if (exp_valid) begin
            chk("wb_data", bus.wb_data, q[0].r);
            chk("wb_rd", bus.wb_rd, q[0].rd);
        end
        check_static("state");

        acc = v && exp_ready;
        ret = exp_valid && rdy;
        pop = ret;
        if (ret) begin
            m_z = q[0].zero;
            if (q[0].op == 4'd0 || q[0].op == 4'd5) m_c = q[0].cout;
            if (q[0].op == 4'd5) m_cmp = q[0].cmp;
        end
        if (q.size() > 0 && q[0].err) begin
`ifdef ALU_WB_ERROR_TRAP_EN
            if (!m_trap) begin
                m_trap = 1'b1;
                m_sticky = 1'b1;
            end else if (clr) begin
                m_trap = 1'b0;
                pop = 1'b1;
            end
`else
            m_sticky = 1'b1;
            pop = 1'b1;
`endif
        end
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(e);
    endtask

    task automatic idle(input int n, input bit rdy);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b0, acc);
    endtask

    // Upstream holds an offered entry until it is taken; a bounded wait counts as a failure.
    task automatic push_hold(input ent_t e, input bit rdy);
        bit acc;
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            step(1'b1, e, rdy, 1'b0, acc);
            done = acc;
        end
        if (!done) chk("push_timeout", 0, 1);
    endtask

    initial begin
        ent_t cur;
        bit   have;
        bit   acc;

        model_reset();
        bus.in_valid = 1'b0;
        bus.in_op = '0;
        bus.in_rd = '0;
        bus.in_r = '0;
        bus.in_cout = 1'b0;
        bus.in_zero = 1'b0;
        bus.in_error = 1'b0;
        bus.in_cmp = '0;
        bus.wb_ready = 1'b0;
        bus.trap_clear = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_wb_valid", bus.wb_valid, 0);
        chk("rst_wb_data", bus.wb_data, 0);
        check_static("rst");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel_in_ready", bus.in_ready, 1);

        // Single sub result, retired immediately
        step(1'b1, mk(5, 3, 16'h0001, 1, 0, 0, 2'b01), 1'b1, 1'b0, acc);
        idle(2, 1'b1);
        chk("plan1_flag_cmp", bus.flag_cmp, 2'b01);
        chk("plan1_flag_c", bus.flag_c, 1);

        // Back-pressure with three add results
        step(1'b1, mk(0, 1, 16'h0005, 0, 0, 0, 0), 1'b0, 1'b0, acc);
        step(1'b1, mk(0, 2, 16'h0006, 0, 0, 0, 0), 1'b0, 1'b0, acc);
        for (int i = 0; i < 3; i++) step(1'b1, mk(0, 3, 16'h0007, 0, 0, 0, 0), 1'b0, 1'b0, acc);
        chk("bp_held_data", bus.wb_data, 16'h0005);
        push_hold(mk(0, 3, 16'h0007, 0, 0, 0, 0), 1'b1);
        idle(3, 1'b1);

        // Streaming at count = 1 with accept and retire every cycle
        step(1'b1, rand_ent() & ~ent_t'(4), 1'b0, 1'b0, acc);
        for (int i = 0; i < 8; i++) begin
            cur = rand_ent();
            cur.err = 1'b0;
            step(1'b1, cur, 1'b1, 1'b0, acc);
            chk("stream_accept", acc, 1);
        end
        idle(2, 1'b1);

        // Flag masking: a logical op leaves carry and compare alone
        push_hold(mk(5, 4, 16'h1234, 0, 0, 0, 2'b00), 1'b1);
        push_hold(mk(1, 5, 16'h0000, 1, 1, 0, 2'b11), 1'b1);
        idle(2, 1'b1);
        chk("mask_flag_z", bus.flag_z, 1);
        chk("mask_flag_c", bus.flag_c, 0);
        chk("mask_flag_cmp", bus.flag_cmp, 2'b00);

        // Error entry between two good entries
        push_hold(mk(0, 6, 16'h00AA, 0, 0, 0, 0), 1'b1);
        push_hold(mk(0, 7, 16'hFFFE, 0, 0, 1, 0), 1'b1);
        idle(4, 1'b1);
        chk("err_sticky_set", bus.err_sticky, 1);
`ifdef ALU_WB_ERROR_TRAP_EN
        chk("err_trap_on", bus.trap, 1);
        chk("err_trap_in_ready", bus.in_ready, 0);
`endif
        step(1'b1, mk(0, 8, 16'h00BB, 0, 0, 0, 0), 1'b1, 1'b1, acc);
        push_hold(mk(0, 8, 16'h00BB, 0, 0, 0, 0), 1'b1);
        idle(3, 1'b1);

        // Reset with two entries buffered under back-pressure
        step(1'b1, mk(0, 9, 16'h0011, 1, 1, 0, 0), 1'b0, 1'b0, acc);
        step(1'b1, mk(5, 10, 16'h0022, 1, 1, 0, 3), 1'b0, 1'b0, acc);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_wb_valid", bus.wb_valid, 0);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        check_static("mid_rst");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);

        // Random traffic, upstream holding each offer until accepted
        have = 1'b0;
        cur = '0;
        for (int i = 0; i < 300; i++) begin
            if (!have && $urandom_range(0, 3) != 0) begin
                cur = rand_ent();
                have = 1'b1;
            end
            step(have, cur, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, acc);
            if (acc) have = 1'b0;
        end
        idle(4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
